// File: rtl/alm_mac_pkg.sv
// ============================================================================
// Module : alm_mac_pkg
// Brief  : Shared widths, operand/product/accumulator types for the soft MAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alm_mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 27;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Sign-extend a full product to the accumulator width.
  function automatic acc_t sxt_prod(input prod_t p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alm_mult_8x8.sv
// ============================================================================
// Module : alm_mult_8x8
// Brief  : Combinational signed 8x8 Baugh-Wooley multiplier, ripple adder rows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alm_mult_8x8
  import alm_mac_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  // Baugh-Wooley correction: a one at column DATA_W and at the product MSB.
  localparam logic [PROD_W-1:0] c_bw_const  = PROD_W'((1 << DATA_W) | (1 << (PROD_W-1)));
  localparam logic [DATA_W-1:0] c_inv_other = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] c_inv_last  = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] w_a;
  logic [PROD_W-1:0] w_pp  [DATA_W];
  logic [PROD_W-1:0] w_sum [DATA_W+1];

  function automatic logic [PROD_W-1:0] ripple_add(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y);
    logic              c;
    logic [PROD_W-1:0] s;
    c = 1'b0;
    s = '0;
    for (int k = 0; k < PROD_W; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    return s;
  endfunction

  assign w_a      = a;
  assign w_sum[0] = c_bw_const;

  for (genvar i = 0; i < DATA_W; i++) begin : g_row
    // Cross terms touching exactly one sign bit are complemented.
    localparam logic [DATA_W-1:0] c_inv = (i == DATA_W-1) ? c_inv_last : c_inv_other;

    assign w_pp[i]    = {{DATA_W{1'b0}}, (w_a & {DATA_W{b[i]}}) ^ c_inv} << i;
    assign w_sum[i+1] = ripple_add(w_sum[i], w_pp[i]);
  end

  assign p = w_sum[DATA_W];

endmodule

`default_nettype wire

// File: rtl/alm_mac_8bit.sv
// ============================================================================
// Module : alm_mac_8bit
// Brief  : Soft-logic signed 8x8 MAC with registered operands and 27-bit acc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alm_mac_8bit
  import alm_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  result
);

  operand_t r_a_q;
  operand_t r_b_q;
  logic     r_en_q;
  acc_t     r_result;

  prod_t    w_prod;
  acc_t     w_prod_ext;
  acc_t     w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_q  <= '0;
      r_b_q  <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_a_q  <= a;
      r_b_q  <= b;
      r_en_q <= acc_en;
    end
  end

  alm_mult_8x8 u_mult (
    .a (r_a_q),
    .b (r_b_q),
    .p (w_prod)
  );

  // Accumulation wraps modulo 2^ACC_W with no saturation.
  assign w_prod_ext = sxt_prod(w_prod);
  assign w_next     = r_en_q ? (r_result + w_prod_ext) : w_prod_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
    end else begin
      r_result <= w_next;
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_alm_mac_8bit.sv
// ============================================================================
// Module : tb_alm_mac_8bit
// Brief  : Self-checking bench: integer reference model plus directed literals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alm_mac_8bit;

  logic               clk;
  logic               reset;
  logic               acc_en;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic signed [26:0] result;

  int total = 0;
  int bad   = 0;

  // Reference: result after an edge = (en of previous sample ? old + prod : prod) mod 2^27.
  longint m_res       = 0;
  longint m_pend_prod = 0;
  bit     m_pend_en   = 1'b0;

  alm_mac_8bit dut (
    .clk    (clk),
    .reset  (reset),
    .acc_en (acc_en),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrap27(input longint v);
    longint r;
    r = v & ((longint'(1) << 27) - 1);
    if (r >= (longint'(1) << 26)) r = r - (longint'(1) << 27);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_res       = 0;
      m_pend_prod = 0;
      m_pend_en   = 1'b0;
    end else begin
      m_res       = wrap27(m_pend_en ? (m_res + m_pend_prod) : m_pend_prod);
      m_pend_prod = longint'(a) * longint'(b);
      m_pend_en   = acc_en;
    end
  end

  always @(posedge clk) begin
    #1;
    check("model", longint'(result), m_res);
  end

  // Drive one operand pair at the falling edge, then look just past the next rising edge.
  task automatic step(input int av, input int bv, input bit en);
    @(negedge clk);
    a      = 8'(av);
    b      = 8'(bv);
    acc_en = en;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset  = 1'b0;
    acc_en = 1'b0;
    a      = '0;
    b      = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a      = 8'($urandom);
      b      = 8'($urandom);
      acc_en = 1'($urandom);
      @(posedge clk);
      #2;
      check("reset_hold", longint'(result), 0);
    end

    // Release between edges with the first chain operands already on the bus.
    @(negedge clk);
    a      = 8'(4);
    b      = 8'(7);
    acc_en = 1'b1;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("first_sample", longint'(result), 0);

    step(8, 9, 1'b1);      check("chain1", longint'(result), 28);
    step(-99, -70, 1'b1);  check("chain2", longint'(result), 100);
    step(65, -121, 1'b1);  check("chain3", longint'(result), 7030);
    step(65, -121, 1'b0);  check("chain4", longint'(result), -835);
    step(65, -121, 1'b0);  check("load1", longint'(result), -7865);
    step(-128, -128, 1'b0); check("load2", longint'(result), -7865);
    step(-128, 127, 1'b0); check("ext_nn", longint'(result), 16384);
    step(127, 127, 1'b0);  check("ext_np", longint'(result), -16256);
    step(0, int'($urandom_range(0, 255)), 1'b0);
    check("ext_pp", longint'(result), 16129);

    step(-128, -128, 1'b1);
    check("ext_zero", longint'(result), 0);
    for (int i = 1; i < 4096; i++) step(-128, -128, 1'b1);
    step(0, 0, 1'b0);
    check("wrap", longint'(result), -67108864);

    for (int i = 0; i < 10000; i++) begin
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #1;
        reset = 1'b0;
        #1;
        check("async_rst", longint'(result), 0);
        @(posedge clk);
        #2;
        check("rst_held", longint'(result), 0);
        reset = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
